// File: rtl/pcie_legacyint_pkg.sv
// pcie_legacyint_pkg: shared state encoding and message codes for the INTx controller
package pcie_legacyint_pkg;
  localparam int MAX_CHAN = 4;
  localparam logic MSG_ASSERT = 1'b1;
  localparam logic MSG_DEASSERT = 1'b0;
  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    ASSERT_PEND   = 2'd1,
    ASSERTED      = 2'd2,
    DEASSERT_PEND = 2'd3
  } chan_state_e;
endpackage

// File: rtl/pcie_legacyint_rr_arb.sv
// pcie_legacyint_rr_arb: round-robin arbiter, search starts one past the last granted index
module pcie_legacyint_rr_arb
  import pcie_legacyint_pkg::*;
#(
  parameter int N_CHAN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CHAN-1:0] req,
  input  logic              adv,
  output logic [N_CHAN-1:0] grant,
  output logic [$clog2(MAX_CHAN)-1:0] idx
);
  logic [$clog2(MAX_CHAN)-1:0] ptr;
  logic found;
  int j;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < N_CHAN; k++) begin
      j = (int'(ptr) + k) % N_CHAN;
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = ($clog2(MAX_CHAN))'(j);
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (adv) ptr <= (idx == ($clog2(MAX_CHAN))'(N_CHAN - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/pcie_legacyint_ctrl.sv
// pcie_legacyint_ctrl: multi-channel INTx controller emitting Assert/Deassert message requests.
// Optional Deassert holdoff timer enabled by PCIE_LEGACYINT_HOLDOFF_EN.
module pcie_legacyint_ctrl
  import pcie_legacyint_pkg::*;
#(
  parameter int N_CHAN = 4
`ifdef PCIE_LEGACYINT_HOLDOFF_EN
  , parameter int HOLDOFF_CYCLES = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CHAN-1:0]     intx_pending_i,
  input  logic                  intx_disable_i,
  output logic                  msg_valid_o,
  input  logic                  msg_ready_i,
  output logic                  msg_assert_o,
  output logic [1:0]            msg_chan_o,
  output logic [N_CHAN-1:0]     intx_status_o,
  output logic [2*N_CHAN-1:0]   state_o
);
  chan_state_e st [N_CHAN];
  chan_state_e st_n [N_CHAN];
  logic [N_CHAN-1:0] eff, pres, acc, ap, dp, cancel, hold_ok, cand, grant;
  logic [1:0] gidx;
  logic hs, load;
  assign eff = intx_pending_i & {N_CHAN{~intx_disable_i}};
  assign hs = msg_valid_o & msg_ready_i;
  assign load = ~msg_valid_o | hs;
  for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
    assign pres[g] = msg_valid_o & (msg_chan_o == 2'(g));
    assign acc[g] = hs & (msg_chan_o == 2'(g));
    assign ap[g] = st[g] == ASSERT_PEND;
    assign dp[g] = st[g] == DEASSERT_PEND;
    assign cancel[g] = ~pres[g] & ((ap[g] & ~eff[g]) | (dp[g] & eff[g]));
    assign st_n[g] = st[g] == IDLE ? (eff[g] ? ASSERT_PEND : IDLE) :
                     ap[g] ? (acc[g] ? ASSERTED : cancel[g] ? IDLE : ASSERT_PEND) :
                     st[g] == ASSERTED ? ((~eff[g] & hold_ok[g]) ? DEASSERT_PEND : ASSERTED) :
                     (acc[g] ? IDLE : cancel[g] ? ASSERTED : DEASSERT_PEND);
    always_ff @(posedge clk_i)
      if (rst_i) st[g] <= IDLE;
      else st[g] <= st_n[g];
    assign state_o[2*g +: 2] = st[g];
    assign intx_status_o[g] = st[g] == ASSERTED || dp[g];
`ifdef PCIE_LEGACYINT_HOLDOFF_EN
    localparam int CW = $clog2(HOLDOFF_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_i)
      if (rst_i) cnt <= '0;
      else if (acc[g] & ap[g]) cnt <= CW'(HOLDOFF_CYCLES);
      else if (st[g] == ASSERTED && cnt != '0) cnt <= cnt - 1'b1;
    assign hold_ok[g] = cnt == '0;
`else
    assign hold_ok[g] = 1'b1;
`endif
  end
  // cancelling channels are excluded so a slot is never loaded for a message that will not exist
  assign cand = (ap | dp) & ~acc & ~cancel;
  pcie_legacyint_rr_arb #(.N_CHAN(N_CHAN)) u_arb (
    .clk(clk_i),
    .rst(rst_i),
    .req(cand),
    .adv(load & |cand),
    .grant(grant),
    .idx(gidx)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      msg_valid_o <= 1'b0;
      msg_assert_o <= MSG_DEASSERT;
      msg_chan_o <= '0;
    end else if (load) begin
      msg_valid_o <= |cand;
      msg_assert_o <= |(grant & ap) ? MSG_ASSERT : MSG_DEASSERT;
      msg_chan_o <= gidx;
    end
endmodule

// File: doc/pcie_legacyint_ctrl.md
Name: pcie_legacyint_ctrl

Overview:
- Multi-channel PCIe legacy interrupt (INTx) controller, successor to the single-channel next-state logic.
- Tracks up to four virtual wires (INTA..INTD), one per-channel state machine each.
- Emits Assert_INTx / Deassert_INTx message requests to the TLP message generator over a valid/ready handshake, with round-robin arbitration between channels.
- Sits between the function's interrupt sources and the TX message path; honours the Command register Interrupt Disable bit.

Parameters:
- N_CHAN, 4, number of INTx channels (1..4); channel i maps to INTA+i.
- HOLDOFF_CYCLES, 16, minimum cycles in ASSERTED before a Deassert may be queued. Used only with PCIE_LEGACYINT_HOLDOFF_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- intx_pending_i  in  N_CHAN  per-channel level interrupt request
- intx_disable_i  in  1  Command.InterruptDisable
- msg_valid_o  out  1  message request valid
- msg_ready_i  in  1  message generator accepts request
- msg_assert_o  out  1  1 = Assert_INTx, 0 = Deassert_INTx
- msg_chan_o  out  2  channel index (0 = INTA)
- intx_status_o  out  N_CHAN  link-side asserted view per channel (Interrupt Status)
- state_o  out  2*N_CHAN  per-channel state, debug

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high; it takes effect on the next clk_i edge, including mid-handshake.
- Reset values:
  - all channel states IDLE
  - msg_valid_o = 0, msg_assert_o = 0, msg_chan_o = 0
  - intx_status_o = 0, state_o = 0
  - round-robin pointer = 0
  - No Deassert is generated for channels that were asserted before reset.
- Effective request per channel: eff[i] = intx_pending_i[i] & ~intx_disable_i.
- Per-channel states: IDLE = 0, ASSERT_PEND = 1, ASSERTED = 2, DEASSERT_PEND = 3.
  - IDLE: eff -> ASSERT_PEND.
  - ASSERT_PEND:
    - assert handshake for this channel -> ASSERTED.
    - eff low and channel not currently presented -> IDLE (cancelled, no message).
  - ASSERTED: ~eff -> DEASSERT_PEND.
  - DEASSERT_PEND:
    - deassert handshake -> IDLE.
    - eff high and not presented -> ASSERTED (cancelled, no message).
- Presentation lock: a presented channel (msg_valid_o high with msg_chan_o = i) cannot cancel. msg_valid_o, msg_assert_o and msg_chan_o stay stable until msg_valid_o & msg_ready_i.
- Output slot:
  - Registered. Loaded when empty, or in the same cycle as a handshake, so back-to-back messages are possible.
  - Candidates: channels in ASSERT_PEND or DEASSERT_PEND that are not the one being accepted.
  - Grant is round-robin, starting at (last granted + 1) mod N_CHAN.
  - msg_assert_o = 1 when the granted state is ASSERT_PEND.
- Latency:
  - pending rises at edge t -> ASSERT_PEND at t+1 -> msg_valid_o at t+2.
  - handshake at edge h -> state update at h.
- Status: intx_status_o[i] = 1 in ASSERTED or DEASSERT_PEND.
- intx_disable_i rising acts as eff falling on every channel:
  - asserted channels issue Deassert;
  - unpresented ASSERT_PEND channels cancel.
- Simultaneous requests from all channels are serviced in round-robin order; no channel is starved.
- msg_ready_i high while msg_valid_o is low is ignored.

Optional Feature:
- Macro: PCIE_LEGACYINT_HOLDOFF_EN.
- Defined:
  - Per-channel counter loads HOLDOFF_CYCLES on Assert acceptance.
  - ASSERTED -> DEASSERT_PEND is allowed only when ~eff and the counter = 0. The counter decrements every cycle in ASSERTED.
  - Reset clears all counters.
- Undefined: no counters are present, and ASSERTED leaves on ~eff immediately.

Decomposition:
- Package pcie_legacyint_pkg holds:
  - the state enum (IDLE, ASSERT_PEND, ASSERTED, DEASSERT_PEND)
  - MSG_ASSERT / MSG_DEASSERT codes
  - MAX_CHAN = 4
- Sub-module pcie_legacyint_rr_arb: N_CHAN-input round-robin arbiter. It takes a request vector and an advance strobe, and gives a one-hot grant plus the index.

Test Plan:
- Reset with intx_pending_i = 4'b1111 held -> all outputs 0. Release -> msg_valid_o high 2 cycles later with chan = 0, assert = 1.
- Single channel 2 (INTC): pending high, ready always 1 -> Assert chan 2; intx_status_o = 4'b0100. Pending low -> Deassert chan 2; status returns to 0.
- All four pending simultaneously, ready = 1 -> Assert messages in chan order 0, 1, 2, 3 on consecutive cycles; each message exactly once.
- Pending pulse of 1 cycle on chan 1 while chan 0 is presented with ready = 0 -> chan 1 cancels; no message for chan 1. Chan 0 message stays stable until ready.
- Channels 0 and 3 asserted, then intx_disable_i = 1 -> Deassert for 0 and 3; status goes to 0 after the handshakes.
- With PCIE_LEGACYINT_HOLDOFF_EN and HOLDOFF_CYCLES = 8: pending drops 2 cycles after Assert acceptance -> Deassert valid no earlier than 8 cycles after acceptance.
